// File: rtl/reg_list_sequencer_pkg.sv
// Shared definitions for the block-transfer (LDM/STM) register-list sequencer.
//   state_e    : sequencer states, encoding fixed so other tools can decode it
//   ADDR_STEP  : byte increment between consecutive transferred words
//   REG_COUNT  : number of architectural registers covered by the list
//   PC_INDEX   : register index that is redirected to the PC on a load
package reg_list_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam int          REG_COUNT = 16;
    localparam logic [3:0]  PC_INDEX  = 4'd15;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit list.
//   bits  in  16  register list (bit i selects Ri)
//   index out 4   position of the lowest set bit (0 when bits == 0)
//   valid out 1   1 when any bit is set
module lowest_set_bit
    import reg_list_sequencer_pkg::*;
(
    input  logic [REG_COUNT-1:0] bits,
    output logic [3:0]           index,
    output logic                 valid
);

    always_comb begin
        index = 4'd0;
        valid = |bits;
        // Scan from the top so the lowest set bit is the last one to win.
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// LDM/STM block-transfer sequencer. Walks a 16-bit register list in ascending
// order, one register per cycle, with increment-after addressing.
//   CLK, RESETn          clock and synchronous active-low reset
//   Start/IsLoad/RegList/Base  transfer request, captured in IDLE
//   A1 / RD1             register-file read port (STM data source)
//   A3 / WD3 / WE3       register-file write port (LDM, R0..R14)
//   PCWrite / PCData     PC redirect for an LDM that includes R15
//   MemAddr/MemWE/MemWD/MemRD  data-memory port
//   Busy / Done / FinalAddr    status, completion pulse, writeback base
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        Start,
    input  logic        IsLoad,
    input  logic [15:0] RegList,
    input  logic [31:0] Base,
    output logic [3:0]  A1,
    input  logic [31:0] RD1,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic        PCWrite,
    output logic [31:0] PCData,
    output logic [31:0] MemAddr,
    output logic        MemWE,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] FinalAddr
);

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] addr_q, addr_d;
    logic        is_load_q, is_load_d;
    logic [31:0] final_addr_q, final_addr_d;

    logic [3:0]  cur_idx;
    logic        cur_valid;
    logic [15:0] remaining_clr;
    logic [31:0] addr_inc;
    logic        xfer_active;
    logic        load_pc;

    lowest_set_bit u_lsb (
        .bits  (remaining_q),
        .index (cur_idx),
        .valid (cur_valid)
    );

    assign remaining_clr = remaining_q & ~(16'd1 << cur_idx);
    assign addr_inc      = addr_q + ADDR_STEP;
    assign xfer_active   = (state_q == ST_XFER) && cur_valid;
    assign load_pc       = is_load_q && (cur_idx == PC_INDEX);

    // Next-state and captured-request logic.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        is_load_d    = is_load_q;
        final_addr_d = final_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    is_load_d   = IsLoad;
                    remaining_d = RegList;
                    addr_d      = Base;
                    if (RegList != 16'd0) begin
                        state_d = ST_XFER;
                    end else begin
                        // Empty list: writeback base is the start address.
                        state_d      = ST_DONE;
                        final_addr_d = Base;
                    end
                end
            end
            ST_XFER: begin
                remaining_d = remaining_clr;
                addr_d      = addr_inc;
                // Leave in the same cycle the last register is transferred,
                // so n set bits cost exactly n XFER cycles.
                if (remaining_clr == 16'd0) begin
                    state_d      = ST_DONE;
                    final_addr_d = addr_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath outputs; every enable and data bus is zero outside XFER.
    always_comb begin
        A1      = 4'd0;
        A3      = 4'd0;
        WE3     = 1'b0;
        PCWrite = 1'b0;
        MemAddr = 32'd0;
        MemWE   = 1'b0;
        if (xfer_active) begin
            MemAddr = addr_q;
            if (is_load_q) begin
                if (load_pc) begin
                    PCWrite = 1'b1;
                end else begin
                    A3  = cur_idx;
                    WE3 = 1'b1;
                end
            end else begin
                A1    = cur_idx;
                MemWE = 1'b1;
            end
        end
    end

    // Data buses kept in separate assigns so the RD1/MemRD return paths do
    // not share a process with the address outputs that produce them.
    assign MemWD  = (xfer_active && !is_load_q)            ? RD1   : 32'd0;
    assign WD3    = (xfer_active && is_load_q && !load_pc) ? MemRD : 32'd0;
    assign PCData = (xfer_active && load_pc)               ? MemRD : 32'd0;

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);
    assign FinalAddr = final_addr_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 16'd0;
            addr_q       <= 32'd0;
            is_load_q    <= 1'b0;
            final_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            is_load_q    <= is_load_d;
            final_addr_q <= final_addr_d;
        end
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench for reg_list_sequencer: a register file and a word
// memory surround the DUT, and a list-level reference model predicts every
// transfer cycle and the final register/memory contents.
module tb_reg_list_sequencer;

    logic        CLK;
    logic        RESETn;
    logic        Start;
    logic        IsLoad;
    logic [15:0] RegList;
    logic [31:0] Base;
    logic [3:0]  A1;
    logic [31:0] RD1;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        PCWrite;
    logic [31:0] PCData;
    logic [31:0] MemAddr;
    logic        MemWE;
    logic [31:0] MemWD;
    logic [31:0] MemRD;
    logic        Busy;
    logic        Done;
    logic [31:0] FinalAddr;

    logic [31:0] rf  [16];
    logic [31:0] mem [256];
    logic [31:0] pc;

    int errors;
    int checks;
    int mem_writes;
    int rf_writes;
    int pc_writes;
    int done_seen;

    reg_list_sequencer dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .Start     (Start),
        .IsLoad    (IsLoad),
        .RegList   (RegList),
        .Base      (Base),
        .A1        (A1),
        .RD1       (RD1),
        .A3        (A3),
        .WD3       (WD3),
        .WE3       (WE3),
        .PCWrite   (PCWrite),
        .PCData    (PCData),
        .MemAddr   (MemAddr),
        .MemWE     (MemWE),
        .MemWD     (MemWD),
        .MemRD     (MemRD),
        .Busy      (Busy),
        .Done      (Done),
        .FinalAddr (FinalAddr)
    );

    assign RD1   = rf[A1];
    assign MemRD = mem[MemAddr[9:2]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: records the writes the DUT requests this
    // cycle, commits them at the rising edge, returns at the next falling edge.
    task automatic tick();
        logic        mwe, rwe, pwe;
        logic [7:0]  ma;
        logic [3:0]  ra;
        logic [31:0] md, rd, pd;
        mwe = MemWE;   ma = MemAddr[9:2]; md = MemWD;
        rwe = WE3;     ra = A3;           rd = WD3;
        pwe = PCWrite; pd = PCData;
        if (Done) done_seen++;
        @(posedge CLK);
        #1;
        if (mwe) begin mem[ma] = md; mem_writes++; end
        if (rwe) begin rf[ra] = rd; rf_writes++; end
        if (pwe) begin pc = pd; pc_writes++; end
        @(negedge CLK);
    endtask

    task automatic randomize_env();
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        pc = $urandom;
    endtask

    task automatic junk_inputs();
        IsLoad  = 1'($urandom);
        RegList = 16'($urandom);
        Base    = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_memwe"}, 32'(MemWE), 32'd0);
        check({tag, "_we3"}, 32'(WE3), 32'd0);
        check({tag, "_pcwrite"}, 32'(PCWrite), 32'd0);
        check({tag, "_buses"}, {A1, A3, 24'd0} | WD3 | MemWD | PCData, 32'd0);
    endtask

    // One complete transfer; glitch > 0 re-asserts Start in that XFER cycle.
    task automatic run_xfer(input logic load, input logic [15:0] list,
                            input logic [31:0] base, input int glitch);
        int          q[$];
        int          n, idx;
        logic [31:0] rf0 [16];
        logic [31:0] mem0 [256];
        logic [31:0] exp_rf [16];
        logic [31:0] exp_mem [256];
        logic [31:0] exp_pc, a, exp_final;
        int          exp_mw, exp_rw, exp_pw, bad;

        // Reference model: ascending register order, word k at base + 4k.
        for (int i = 0; i < 16; i++) if (list[i]) q.push_back(i);
        n = q.size();
        rf0 = rf; mem0 = mem; exp_rf = rf; exp_mem = mem; exp_pc = pc;
        exp_mw = 0; exp_rw = 0; exp_pw = 0;
        for (int k = 0; k < n; k++) begin
            a = base + 32'(4 * k);
            if (!load) begin
                exp_mem[a[9:2]] = rf0[q[k]]; exp_mw++;
            end else if (q[k] == 15) begin
                exp_pc = mem0[a[9:2]]; exp_pw++;
            end else begin
                exp_rf[q[k]] = mem0[a[9:2]]; exp_rw++;
            end
        end
        exp_final = base + 32'(4 * n);
        mem_writes = 0; rf_writes = 0; pc_writes = 0; done_seen = 0;

        check("idle_busy", 32'(Busy), 32'd0);
        Start = 1'b1; IsLoad = load; RegList = list; Base = base;
        tick();
        for (int k = 0; k < n; k++) begin
            idx = q[k];
            a = base + 32'(4 * k);
            Start = (k + 1 == glitch);
            junk_inputs();
            check("xfer_busy", 32'(Busy), 32'd1);
            check("xfer_done", 32'(Done), 32'd0);
            check("xfer_memaddr", MemAddr, a);
            if (!load) begin
                check("stm_memwe", 32'(MemWE), 32'd1);
                check("stm_a1", 32'(A1), 32'(idx));
                check("stm_memwd", MemWD, rf0[idx]);
                check("stm_we3", 32'(WE3), 32'd0);
                check("stm_pcwrite", 32'(PCWrite), 32'd0);
            end else if (idx == 15) begin
                check("ldm_pc_pcwrite", 32'(PCWrite), 32'd1);
                check("ldm_pc_pcdata", PCData, mem0[a[9:2]]);
                check("ldm_pc_we3", 32'(WE3), 32'd0);
                check("ldm_pc_memwe", 32'(MemWE), 32'd0);
            end else begin
                check("ldm_we3", 32'(WE3), 32'd1);
                check("ldm_a3", 32'(A3), 32'(idx));
                check("ldm_wd3", WD3, mem0[a[9:2]]);
                check("ldm_pcwrite", 32'(PCWrite), 32'd0);
                check("ldm_memwe", 32'(MemWE), 32'd0);
            end
            tick();
        end
        Start = 1'b0;
        check("done_pulse", 32'(Done), 32'd1);
        check("done_busy", 32'(Busy), 32'd1);
        check("done_finaladdr", FinalAddr, exp_final);
        check_quiet("done");
        tick();
        check("after_busy", 32'(Busy), 32'd0);
        check("after_done", 32'(Done), 32'd0);
        check("after_finaladdr", FinalAddr, exp_final);
        tick();
        check("hold_finaladdr", FinalAddr, exp_final);
        check("done_count", 32'(done_seen), 32'd1);
        check("mem_write_count", 32'(mem_writes), 32'(exp_mw));
        check("rf_write_count", 32'(rf_writes), 32'(exp_rw));
        check("pc_write_count", 32'(pc_writes), 32'(exp_pw));
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        for (int i = 0; i < 16; i++) if (rf[i] !== exp_rf[i]) bad++;
        check("final_contents_mismatches", 32'(bad), 32'd0);
        check("final_pc", pc, exp_pc);
        $display("xfer load=%0d list=0x%04h base=0x%08h n=%0d final=0x%08h errors=%0d",
                 load, list, base, n, FinalAddr, errors);
    endtask

    initial begin
        logic [31:0] r0_exp, base_r;
        logic [31:0] rf_keep [16];
        int          bad;

        errors = 0; checks = 0;
        RESETn = 1'b0; Start = 1'b0; IsLoad = 1'b0; RegList = 16'd0; Base = 32'd0;
        randomize_env();
        @(negedge CLK);
        tick();
        tick();
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_finaladdr", FinalAddr, 32'd0);
        check_quiet("reset");
        RESETn = 1'b1;
        tick();

        // Two-register store.
        randomize_env();
        rf[0] = 32'hAA; rf[2] = 32'hBB;
        run_xfer(1'b0, 16'h0005, 32'h0000_0100, 0);
        check("stm_mem_100", mem[8'h40], 32'hAA);
        check("stm_mem_104", mem[8'h41], 32'hBB);

        // Load into R1 and the PC.
        randomize_env();
        mem[8'h80] = 32'h11; mem[8'h81] = 32'h40;
        run_xfer(1'b1, 16'h8002, 32'h0000_0200, 0);
        check("ldm_r1", rf[1], 32'h11);
        check("ldm_pc", pc, 32'h40);

        // Empty lists.
        randomize_env();
        run_xfer(1'b0, 16'h0000, 32'h0000_0300, 0);
        run_xfer(1'b1, 16'h0000, 32'h0000_0300, 0);

        // Full list, address wraps through zero.
        randomize_env();
        run_xfer(1'b0, 16'hFFFF, 32'hFFFF_FFF0, 0);
        run_xfer(1'b1, 16'hFFFF, 32'hFFFF_FFF0, 0);

        // Start re-asserted mid-transfer must be ignored.
        randomize_env();
        run_xfer(1'b0, 16'h1111, 32'h0000_0400, 2);
        run_xfer(1'b1, 16'h0C30, 32'h0000_0500, 2);

        // Reset in the second cycle of a four-register load.
        randomize_env();
        base_r = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        r0_exp = mem[base_r[9:2]];
        rf_keep = rf;
        mem_writes = 0; rf_writes = 0; pc_writes = 0; done_seen = 0;
        Start = 1'b1; IsLoad = 1'b1; RegList = 16'h000F; Base = base_r;
        tick();
        Start = 1'b0;
        check("rst_cycle1_we3", 32'(WE3), 32'd1);
        check("rst_cycle1_a3", 32'(A3), 32'd0);
        RESETn = 1'b0;
        tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_finaladdr", FinalAddr, 32'd0);
        check_quiet("rst");
        RESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            junk_inputs();
            tick();
            check("rst_idle_busy", 32'(Busy), 32'd0);
        end
        check("rst_done_count", 32'(done_seen), 32'd0);
        check("rst_rf_writes", 32'(rf_writes), 32'd1);
        check("rst_r0", rf[0], r0_exp);
        bad = 0;
        for (int i = 1; i < 16; i++) if (rf[i] !== rf_keep[i]) bad++;
        check("rst_untouched_regs", 32'(bad), 32'd0);
        $display("reset-abort load=1 list=0x000f base=0x%08h errors=%0d", base_r, errors);

        // Random transfers.
        for (int t = 0; t < 24; t++) begin
            logic [15:0] lst;
            randomize_env();
            case ($urandom_range(0, 7))
                0:       lst = 16'h0000;
                1:       lst = 16'hFFFF;
                2:       lst = 16'h8000;
                default: lst = 16'($urandom);
            endcase
            run_xfer(1'($urandom), lst, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                     int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_list_sequencer.md
REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 RESETn  in  1  reset, synchronous and active-low.
REQ-004 Start  in  1  request a block transfer; sampled only in IDLE.
REQ-005 IsLoad  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory); captured with Start.
REQ-006 RegList  in  16  register list; bit i selects Ri; captured with Start.
REQ-007 Base  in  32  start address, word aligned; captured with Start.
REQ-008 A1  out  4  register-file read index (STM data source).
REQ-009 RD1  in  32  register-file read data for A1, combinational, R15 already substituted.
REQ-010 A3 / WD3 / WE3  out  4/32/1  register-file write index, data and active-high enable (LDM).
REQ-011 PCWrite / PCData  out  1/32  redirect for an LDM into R15; the register file holds no R15.
REQ-012 MemAddr / MemWE / MemWD  out  32/1/32  data-memory address, write enable and write data.
REQ-013 MemRD  in  32  data-memory read data, combinational from MemAddr.
REQ-014 Busy / Done / FinalAddr  out  1/1/32  transfer in progress, one-cycle completion pulse, writeback base value.

Function
REQ-015 The FSM SHALL have states IDLE, XFER and DONE.
REQ-016 IDLE with Start=1 SHALL capture IsLoad, RegList into Remaining and Base into Addr; next state XFER if RegList!=0, otherwise DONE.
REQ-017 In XFER the active index SHALL be the lowest set bit of Remaining, giving ascending register order (increment-after).
REQ-018 STM XFER cycle: A1=index, MemAddr=Addr, MemWD=RD1, MemWE=1; WE3=0, PCWrite=0.
REQ-019 LDM XFER cycle, index<15: MemAddr=Addr, A3=index, WD3=MemRD, WE3=1; MemWE=0.
REQ-020 LDM XFER cycle, index=15: PCWrite=1, PCData=MemRD; WE3=0.
REQ-021 Each XFER cycle SHALL clear the active bit in Remaining and set Addr=Addr+4 (mod 2^32, wraps silently).
REQ-022 XFER SHALL move to DONE in the cycle the last set bit is cleared; a list with n set bits takes exactly n XFER cycles.
REQ-023 DONE SHALL assert Done=1 for one cycle, present FinalAddr=Base+4*n, then return to IDLE.
REQ-024 FinalAddr SHALL hold its value until the next accepted Start.
REQ-025 Busy SHALL be 1 in XFER and DONE and 0 in IDLE; Start while Busy SHALL be ignored with no state change.
REQ-026 Outside XFER, WE3, MemWE and PCWrite SHALL be 0; A1, A3, WD3, MemWD and PCData SHALL be 0.
REQ-027 Latency: Start accepted at cycle 0, transfers at cycles 1..n, Done at cycle n+1, next Start accepted at cycle n+2.

Reset
REQ-028 RESETn=0 at a rising CLK edge SHALL force IDLE and clear Remaining, Addr and FinalAddr to 0.
REQ-029 Reset during XFER SHALL abort the transfer; remaining registers stay unwritten, Done is not pulsed, and all enables are 0 from the next cycle.

Structure
REQ-030 The state encoding (IDLE=0, XFER=1, DONE=2) and the address step constant 4 SHALL live in a shared package.
REQ-031 The lowest-set-bit selection SHALL be a combinational sub-module, lowest_set_bit (16-bit in; 4-bit index and valid out).

Verification
REQ-032 STM, RegList=0x0005, Base=0x100, R0=0xAA, R2=0xBB -> cycle 1 writes Mem[0x100]=0xAA, cycle 2 writes Mem[0x104]=0xBB; Done at cycle 3; FinalAddr=0x108.
REQ-033 LDM, RegList=0x8002, Base=0x200, Mem[0x200]=0x11, Mem[0x204]=0x40 -> cycle 1 WE3=1, A3=1, WD3=0x11; cycle 2 PCWrite=1, PCData=0x40, WE3=0; FinalAddr=0x208.
REQ-034 RegList=0x0000, Base=0x300 -> no memory or register write; Done at cycle 1; FinalAddr=0x300.
REQ-035 RegList=0xFFFF, Base=0xFFFFFFF0, STM -> 16 writes, addresses wrap through 0x0; Done at cycle 17; FinalAddr=0x30.
REQ-036 Start pulsed again at cycle 2 of a 4-register transfer -> ignored, original sequence completes unchanged.
REQ-037 RESETn=0 at cycle 2 of an LDM with RegList=0x000F -> only R0 written; IDLE, Busy=0 and no Done pulse afterward.
